// File: rtl/imuldiv_int_mul_div_iterative_if.sv
// Request/response bundle for the iterative integer multiply/divide unit.
// master issues requests and accepts results; slave is the unit itself.
interface imuldiv_int_mul_div_iterative_if;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic        muldivreq_val;
  logic        muldivreq_rdy;
  logic [31:0] muldivresp_msg_result;
  logic        muldivresp_val;
  logic        muldivresp_rdy;

  modport master (
    output muldivreq_msg_fn,
    output muldivreq_msg_a,
    output muldivreq_msg_b,
    output muldivreq_val,
    input  muldivreq_rdy,
    input  muldivresp_msg_result,
    input  muldivresp_val,
    output muldivresp_rdy
  );

  modport slave (
    input  muldivreq_msg_fn,
    input  muldivreq_msg_a,
    input  muldivreq_msg_b,
    input  muldivreq_val,
    output muldivreq_rdy,
    output muldivresp_msg_result,
    output muldivresp_val,
    input  muldivresp_rdy
  );
endinterface

// File: rtl/imuldiv_int_mul_div_iterative.sv
// Iterative 32-bit MUL/DIV/DIVU/REM/REMU unit: one bit per cycle,
// 32 iterations, single transaction in flight.
module imuldiv_int_mul_div_iterative (
  input  logic clk,
  input  logic reset,
  imuldiv_int_mul_div_iterative_if.slave io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  fn_q;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] acc;
  logic [31:0] result_q;
  logic        neg_q;
  logic        neg_r;
  logic        dbz;

  logic        is_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic [31:0] acc_mul;
  logic [31:0] a_mul;
  logic [31:0] b_mul;

  logic [32:0] shl;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] rem_n;
  logic [31:0] quo_n;
  logic [31:0] res_fin;

  // signed ops work on magnitudes; signs are restored at the end
  always_comb begin
    is_signed = (io.muldivreq_msg_fn == FN_DIV)
             || (io.muldivreq_msg_fn == FN_REM);
    a_mag = io.muldivreq_msg_a;
    b_mag = io.muldivreq_msg_b;
    if (is_signed && io.muldivreq_msg_a[31])
      a_mag = -io.muldivreq_msg_a;
    if (is_signed && io.muldivreq_msg_b[31])
      b_mag = -io.muldivreq_msg_b;
  end

  always_comb begin
    acc_mul = acc + (op_b[0] ? op_a : 32'd0);
    a_mul   = op_a << 1;
    b_mul   = op_b >> 1;
  end

  // restoring step: op_a shifts dividend out and quotient in
  always_comb begin
    shl   = {acc, op_a[31]};
    diff  = shl - {1'b0, op_b};
    ge    = ~diff[32];
    rem_n = ge ? diff[31:0] : shl[31:0];
    quo_n = {op_a[30:0], ge};
  end

  always_comb begin
    res_fin = 32'd0;
    case (fn_q)
      FN_MUL:  res_fin = acc_mul;
      FN_DIV:  res_fin = dbz   ? 32'hFFFF_FFFF
                       : neg_q ? -quo_n : quo_n;
      FN_DIVU: res_fin = dbz ? 32'hFFFF_FFFF : quo_n;
      FN_REM:  res_fin = neg_r ? -rem_n : rem_n;
      FN_REMU: res_fin = rem_n;
      default: res_fin = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      fn_q     <= 3'd0;
      op_a     <= 32'd0;
      op_b     <= 32'd0;
      acc      <= 32'd0;
      result_q <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.muldivreq_val) begin
            fn_q  <= io.muldivreq_msg_fn;
            op_a  <= a_mag;
            op_b  <= b_mag;
            acc   <= 32'd0;
            cnt   <= 5'd0;
            neg_q <= is_signed
                   & (io.muldivreq_msg_a[31]
                   ^  io.muldivreq_msg_b[31]);
            neg_r <= is_signed & io.muldivreq_msg_a[31];
            dbz   <= (io.muldivreq_msg_b == 32'd0);
            state <= CALC;
          end
        end
        CALC: begin
          if (fn_q == FN_MUL) begin
            acc  <= acc_mul;
            op_a <= a_mul;
            op_b <= b_mul;
          end else begin
            acc  <= rem_n;
            op_a <= quo_n;
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result_q <= res_fin;
            state    <= DONE;
          end
        end
        DONE: begin
          if (io.muldivresp_rdy) begin
            result_q <= 32'd0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.muldivreq_rdy  = (state == IDLE) & ~reset;
  assign io.muldivresp_val = (state == DONE) & ~reset;
  assign io.muldivresp_msg_result =
    io.muldivresp_val ? result_q : 32'd0;

endmodule

// File: tb/tb_imuldiv_int_mul_div_iterative.sv
// Scoreboard bench for the iterative mul/div unit: random and
// directed requests, backpressure and reset-abort.
module tb_imuldiv_int_mul_div_iterative;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imuldiv_int_mul_div_iterative_if io ();

  imuldiv_int_mul_div_iterative dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_edge = 0;
  bit bp_mode = 1'b1;
  bit prev_val = 1'b0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(
    input logic [2:0] fn,
    input logic [31:0] a,
    input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [63:0] p;
    bit ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (fn)
      3'd0: begin p = a * b; return p[31:0]; end
      3'd1: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return sa / sb;
      end
      3'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd3: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return sa % sb;
      end
      3'd4: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      5: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // called and returns 1 time unit after a rising edge
  task automatic issue_exp(input logic [2:0] fn,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [31:0] exp);
    int n = 0;
    while (!io.muldivreq_rdy) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        checks++;
        failures++;
        $display("FAIL issue_timeout: req_rdy low %0d cycles", n);
        return;
      end
    end
    io.muldivreq_msg_fn = fn;
    io.muldivreq_msg_a  = a;
    io.muldivreq_msg_b  = b;
    io.muldivreq_val    = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    accept_edge = cyc;
    io.muldivreq_val    = 1'b0;
    io.muldivreq_msg_fn = 3'($urandom);
    io.muldivreq_msg_a  = $urandom;
    io.muldivreq_msg_b  = $urandom;
  endtask

  task automatic issue(input logic [2:0] fn,
                       input logic [31:0] a,
                       input logic [31:0] b);
    issue_exp(fn, a, b, ref_model(fn, a, b));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 || !io.muldivreq_rdy) begin
      @(posedge clk); #1;
      n++;
      if (n > 2000) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout: %0d pending",
                 exp_q.size());
        return;
      end
    end
  endtask

  // random consumer backpressure
  initial forever begin
    @(posedge clk); #1;
    if (!bp_mode)
      io.muldivresp_rdy = ($urandom_range(0, 3) != 0);
  end

  // monitor: handshake completes at the next rising edge
  initial forever begin
    @(negedge clk);
    if (io.muldivresp_val) begin
      check("req_rdy_in_done", 32'(io.muldivreq_rdy), 32'd0);
      if (!prev_val)
        check("latency", 32'(cyc - accept_edge), 32'd32);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got %h expected none",
                 io.muldivresp_msg_result);
      end else begin
        check("result", io.muldivresp_msg_result, exp_q[0]);
        if (io.muldivresp_rdy) void'(exp_q.pop_front());
      end
    end else begin
      check("result_not_done", io.muldivresp_msg_result, 32'd0);
    end
    prev_val = io.muldivresp_val;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    bit saw_val;
    int n;
    reset = 1'b1;
    io.muldivreq_val    = 1'b0;
    io.muldivreq_msg_fn = 3'd0;
    io.muldivreq_msg_a  = 32'd0;
    io.muldivreq_msg_b  = 32'd0;
    io.muldivresp_rdy   = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_req_rdy", 32'(io.muldivreq_rdy), 32'd0);
    check("rst_resp_val", 32'(io.muldivresp_val), 32'd0);
    check("rst_result", io.muldivresp_msg_result, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_rdy", 32'(io.muldivreq_rdy), 32'd1);
    @(posedge clk); #1;

    io.muldivresp_rdy = 1'b1;
    issue_exp(3'd0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001);
    issue_exp(3'd0, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFA);
    issue_exp(3'd1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    issue_exp(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    issue_exp(3'd2, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
    issue_exp(3'd4, 32'h8000_0000, 32'd0, 32'h8000_0000);
    issue_exp(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue_exp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    issue_exp(3'd1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    issue_exp(3'd3, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    issue_exp(3'd5, 32'd12, 32'd3, 32'd0);
    issue_exp(3'd7, 32'd12, 32'd3, 32'd0);
    drain();

    bp_mode = 1'b0;
    repeat (150)
      issue(3'($urandom_range(0, 7)), pick_op(), pick_op());
    drain();

    bp_mode = 1'b1;
    io.muldivresp_rdy = 1'b0;
    issue_exp(3'd0, 32'd12345, 32'd6789, 32'd83810205);
    n = 0;
    while (!io.muldivresp_val && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_resp_val", 32'(io.muldivresp_val), 32'd1);
    held = io.muldivresp_msg_result;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_stable", io.muldivresp_msg_result, held);
      check("bp_req_rdy", 32'(io.muldivreq_rdy), 32'd0);
    end
    io.muldivresp_rdy = 1'b1;
    @(posedge clk); #1;
    check("rdy_after_resp", 32'(io.muldivreq_rdy), 32'd1);

    issue(3'd2, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("abort_rdy", 32'(io.muldivreq_rdy), 32'd1);
    saw_val = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (io.muldivresp_val) saw_val = 1'b1;
    end
    check("abort_no_resp", 32'(saw_val), 32'd0);

    issue_exp(3'd2, 32'd100, 32'd7, 32'h0000_000E);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/imuldiv_int_mul_div_iterative.md
IMULDIV_INT_MUL_DIV_ITERATIVE -- requirements
Module: imuldiv_IntMulDivIterative

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 muldivreq_msg_fn  input  3  op code: MUL=0, DIV=1, DIVU=2, REM=3, REMU=4; 5-7 illegal.
REQ-006 muldivreq_msg_a  input  32  operand A (dividend or multiplicand).
REQ-007 muldivreq_msg_b  input  32  operand B (divisor or multiplier).
REQ-008 muldivreq_val  input  1  request valid.
REQ-009 muldivreq_rdy  output  1  block can accept a request.
REQ-010 muldivresp_msg_result  output  32  result.
REQ-011 muldivresp_val  output  1  result valid.
REQ-012 muldivresp_rdy  input  1  consumer accepts the result.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 muldivreq_rdy SHALL be 1 only in IDLE with reset low; muldivresp_val SHALL be 1 only in DONE.
REQ-015 Request go: val && rdy at a rising edge; the block latches fn, a and b, loads counter=0 and moves IDLE->CALC.
REQ-016 Inputs SHALL be ignored outside IDLE; later changes to fn, a or b SHALL NOT affect an in-flight operation.
REQ-017 CALC SHALL perform exactly one iteration per edge for 32 edges (counter 0..31), then move to DONE.
REQ-018 The accepting edge is edge 1 and CALC spans edges 2-33; muldivresp_val SHALL first be high after edge 33.
REQ-019 MUL: iterative shift-add; result = low 32 bits of a*b, identical for signed and unsigned operands.
REQ-020 DIV/REM: restoring division on operand magnitudes; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-021 DIVU/REMU: restoring division on the unsigned operands.
REQ-022 Divide by zero: DIV and DIVU SHALL return 0xFFFFFFFF; REM and REMU SHALL return a.
REQ-023 Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0x00000000.
REQ-024 Illegal fn: the block SHALL take the same 33-edge latency and return 0x00000000.
REQ-025 DONE SHALL hold muldivresp_msg_result stable until the response handshake (val && rdy) occurs.
REQ-026 On the response handshake, the state SHALL move DONE->IDLE, so muldivreq_rdy returns high in the following cycle.
REQ-027 The block SHALL NOT accept a request in the same cycle as a response handshake.
REQ-028 The block SHALL hold at most one transaction in flight.
REQ-029 muldivresp_msg_result SHALL be 0 in IDLE and CALC.

Reset
REQ-030 With reset high at an edge, state SHALL become IDLE and counter, operand and accumulator registers SHALL clear to 0.
REQ-031 While reset is high: muldivreq_rdy=0, muldivresp_val=0, muldivresp_msg_result=0.
REQ-032 Reset asserted in CALC or DONE SHALL abort the operation; the aborted operation SHALL produce no response.
REQ-033 muldivreq_rdy SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-034 MUL a=0x0000FFFF, b=0x0000FFFF -> result 0xFFFE0001; resp_val first high after edge 33.
REQ-035 MUL a=0x00000003, b=0xFFFFFFFE -> 0xFFFFFFFA.
REQ-036 Signed division, a=0xFFFFFFF9, b=0x00000002: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-037 Unsigned divide by zero, a=0x80000000, b=0: DIVU -> 0xFFFFFFFF; REMU -> 0x80000000.
REQ-038 Signed overflow, a=0x80000000, b=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0x00000000.
REQ-039 Backpressure and reset-abort (one bench sequence):
 - hold resp_rdy=0 for 5 cycles in DONE -> result stable and req_rdy=0 throughout;
 - then assert reset for one edge 10 cycles into a new CALC -> resp_val stays 0 and req_rdy=1 the cycle after;
 - then DIVU a=100, b=7 -> 0x0000000E.
